// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin drain of four source FIFOs into one destination FIFO
// Optional per-queue pop statistics enabled by defining ARB_STATS_EN.
module fifo_rr_arbiter #(
    parameter int data_width = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                empty_in,
    input  logic [4*data_width-1:0]   data_in,
    input  logic                      dst_almost_full,
    input  logic                      dst_full,
    output logic [3:0]                pop,
    output logic                      push,
    output logic [data_width-1:0]     data_out,
    output logic [1:0]                state,
    output logic                      error
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]               pop_count
`endif
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_pop;
    logic       r_push;
    logic [1:0] r_sel;
    logic [1:0] r_last_grant;
    logic       r_error;

    logic       w_pop_en;
    logic       w_grant_valid;
    logic [1:0] w_grant_idx;
    logic [1:0] w_idx;
    logic [3:0] w_pop_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:   w_state_next = ST_IDLE;
            ST_IDLE:   if (empty_in != 4'b1111) w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (empty_in == 4'b1111 && r_pop == 4'b0000) w_state_next = ST_IDLE;
            default:   w_state_next = ST_INIT;
        endcase
    end

    always_comb begin
        w_pop_en = (r_state == ST_ACTIVE) && !dst_almost_full && !dst_full;
    end

    // The queue being popped right now is skipped: its empty flag is one read stale.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = r_last_grant;
        w_idx         = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + k[1:0];
            if (!w_grant_valid && !empty_in[w_idx] && !r_pop[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_idx;
            end
        end
        w_pop_next = (w_pop_en && w_grant_valid) ? (4'b0001 << w_grant_idx) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop        <= 4'b0000;
            r_push       <= 1'b0;
            r_sel        <= 2'd0;
            r_last_grant <= 2'd3;
            r_error      <= 1'b0;
        end else begin
            r_pop  <= w_pop_next;
            r_push <= |r_pop;
            r_sel  <= r_last_grant;
            if (w_pop_next != 4'b0000) begin
                r_last_grant <= w_grant_idx;
            end
            if (r_push && dst_full) begin
                r_error <= 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [3:0][7:0] r_pop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_count <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_pop[i] && r_pop_count[i] != 8'hff) begin
                    r_pop_count[i] <= r_pop_count[i] + 8'd1;
                end
            end
        end
    end

    assign pop_count = r_pop_count;
`endif

    // Source data arrives the cycle after pop, so the word is muxed from the delayed grant.
    assign data_out = r_push ? data_in[int'(r_sel)*data_width +: data_width] : '0;
    assign pop      = r_pop;
    assign push     = r_push;
    assign state    = r_state;
    assign error    = r_error;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

    localparam int W = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     empty_in;
    logic [4*W-1:0] data_in;
    logic           dst_almost_full;
    logic           dst_full;
    logic [3:0]     pop;
    logic           push;
    logic [W-1:0]   data_out;
    logic [1:0]     state;
    logic           error;
`ifdef ARB_STATS_EN
    logic [31:0]    pop_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] val [4];

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.data_width(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .empty_in        (empty_in),
        .data_in         (data_in),
        .dst_almost_full (dst_almost_full),
        .dst_full        (dst_full),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .state           (state),
        .error           (error)
`ifdef ARB_STATS_EN
        ,
        .pop_count       (pop_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_pop, input logic e_push,
                             input logic [W-1:0] e_data);
        check({tag, ".pop"}, {28'd0, pop}, {28'd0, e_pop});
        check({tag, ".push"}, {31'd0, push}, {31'd0, e_push});
        check({tag, ".data"}, {22'd0, data_out}, {22'd0, e_data});
    endtask

    initial begin
        val[0] = 10'd100;
        val[1] = 10'd200;
        val[2] = 10'd300;
        val[3] = 10'd400;
        data_in = {val[3], val[2], val[1], val[0]};
        reset = 1'b1;
        empty_in = 4'b1111;
        dst_almost_full = 1'b0;
        dst_full = 1'b0;
        tick();
        tick();
        check("rst.state", {30'd0, state}, 32'd0);
        check("rst.error", {31'd0, error}, 32'd0);
        check_out("rst", 4'b0000, 1'b0, '0);

        // reset release with everything empty: INIT for one cycle, then IDLE
        reset = 1'b0;
        tick();
        check("init2idle.state", {30'd0, state}, 32'd1);
        check_out("init2idle", 4'b0000, 1'b0, '0);
        tick();
        check("idle_hold.state", {30'd0, state}, 32'd1);
        check_out("idle_hold", 4'b0000, 1'b0, '0);

        // all queues full of data: strict rotation, one word per cycle
        empty_in = 4'b0000;
        tick();
        check("go_active.state", {30'd0, state}, 32'd2);
        check_out("go_active", 4'b0000, 1'b0, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("stream.pop", {28'd0, pop}, 32'd1 << (k % 4));
            if (k == 0) begin
                check_out("stream0", 4'b0001, 1'b0, '0);
            end else begin
                check("stream.push", {31'd0, push}, 32'd1);
                check("stream.data", {22'd0, data_out}, {22'd0, val[(k - 1) % 4]});
            end
        end

        // almost-full: one trailing push, then silence until the flag drops
        dst_almost_full = 1'b1;
        tick();
        check_out("af_trail", 4'b0000, 1'b1, val[3]);
        tick();
        check_out("af_quiet1", 4'b0000, 1'b0, '0);
        tick();
        check_out("af_quiet2", 4'b0000, 1'b0, '0);
        dst_almost_full = 1'b0;
        tick();
        check_out("af_resume", 4'b0001, 1'b0, '0);
        tick();
        check_out("af_next", 4'b0010, 1'b1, val[0]);

        // single non-empty queue: bubble between consecutive pops
        empty_in = 4'b1011;
        tick();
        check_out("solo1", 4'b0100, 1'b1, val[1]);
        tick();
        check_out("solo2", 4'b0000, 1'b1, val[2]);
        tick();
        check_out("solo3", 4'b0100, 1'b0, '0);
        tick();
        check_out("solo4", 4'b0000, 1'b1, val[2]);

        // drained and no pop outstanding: back to IDLE
        empty_in = 4'b1111;
        tick();
        check("to_idle.state", {30'd0, state}, 32'd1);
        check_out("to_idle", 4'b0000, 1'b0, '0);

        // overflow: push while destination full sets a sticky error
        empty_in = 4'b0000;
        data_in = {10'd41, 10'd31, 10'd21, 10'd11};
        tick();
        check("ovf_active.state", {30'd0, state}, 32'd2);
        tick();
        check_out("ovf_pop3", 4'b1000, 1'b0, '0);
        tick();
        check_out("ovf_pop0", 4'b0001, 1'b1, 10'd41);
        dst_full = 1'b1;
        check("ovf_before.error", {31'd0, error}, 32'd0);
        tick();
        check("ovf_set.error", {31'd0, error}, 32'd1);
        check_out("ovf_set", 4'b0000, 1'b1, 10'd11);
        dst_full = 1'b0;
        tick();
        check("ovf_hold1.error", {31'd0, error}, 32'd1);
        check_out("ovf_hold1", 4'b0010, 1'b0, '0);
        tick();
        check("ovf_hold2.error", {31'd0, error}, 32'd1);
        check_out("ovf_hold2", 4'b0100, 1'b1, 10'd21);

        // reset mid-stream clears everything on the same edge
        reset = 1'b1;
        tick();
        check("midrst.state", {30'd0, state}, 32'd0);
        check("midrst.error", {31'd0, error}, 32'd0);
        check_out("midrst", 4'b0000, 1'b0, '0);
        reset = 1'b0;
        tick();
        check("midrst_rel.state", {30'd0, state}, 32'd1);
        tick();
        check("midrst_act.state", {30'd0, state}, 32'd2);
        tick();
        check_out("midrst_first", 4'b0001, 1'b0, '0);

`ifdef ARB_STATS_EN
        begin
            int n1;
            int n0;
            reset = 1'b1;
            tick();
            check("stats_rst", pop_count, 32'd0);
            reset = 1'b0;
            empty_in = 4'b1101;
            n1 = 0;
            for (int c = 0; c < 1000 && n1 < 300; c++) begin
                tick();
                if (pop == 4'b0010) n1++;
            end
            check("stats_q1_pops", n1, 32'd300);
            empty_in = 4'b1110;
            n0 = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (pop == 4'b0001) n0++;
            end
            empty_in = 4'b1111;
            tick();
            tick();
            check("stats_q1_sat", {24'd0, pop_count[15:8]}, 32'd255);
            check("stats_q0", {24'd0, pop_count[7:0]}, n0);
            check("stats_q0_nonzero", {31'd0, (n0 > 3)}, 32'd1);
            check("stats_q32", {16'd0, pop_count[31:16]}, 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter: data_width, default 10, width of one data word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 empty_in  input  4  empty flag of source FIFO i; bit i = 1 means queue i is empty.
REQ-005 data_in  input  4*data_width  read data of source FIFO i, in slice [i*data_width +: data_width].
REQ-006 dst_almost_full  input  1  almost-full flag of the destination FIFO.
REQ-007 dst_full  input  1  full flag of the destination FIFO.
REQ-008 pop  output  4  registered, one-hot-or-zero pop strobe to source FIFO i.
REQ-009 push  output  1  registered push strobe to the destination FIFO.
REQ-010 data_out  output  data_width  word driven to the destination FIFO; valid while push=1.
REQ-011 state  output  2  current FSM state: INIT=0, IDLE=1, ACTIVE=2.
REQ-012 error  output  1  sticky destination-overflow flag.

Function
REQ-013 The FSM SHALL go INIT -> IDLE unconditionally one cycle after reset deasserts.
REQ-014 IDLE -> ACTIVE SHALL occur at the edge where empty_in != 4'b1111.
REQ-015 ACTIVE -> IDLE SHALL occur at the edge where empty_in == 4'b1111 and pop == 0.
REQ-016 pop SHALL be nonzero only in the cycle after an edge that samples state == ACTIVE, dst_almost_full == 0 and dst_full == 0.
REQ-017 Grant search SHALL be round-robin: start at (last_grant+1) mod 4, pick the first queue with empty_in[i] == 0.
REQ-018 The search SHALL exclude the queue popped in the current cycle (pop[i] == 1).
- If that queue is the only non-empty one, pop SHALL be 0 for the next cycle (one-cycle bubble).
- Purpose: no underflow from stale empty flags.
REQ-019 last_grant SHALL update to i only when pop[i] is asserted; it resets to 3, so queue 0 wins first.
REQ-020 Source FIFOs present read data one cycle after pop.
- push SHALL equal the OR of pop delayed one cycle.
- data_out SHALL be the data_in slice selected by the grant index delayed one cycle.
- Latency pop -> push is exactly 1 cycle.
- data_out SHALL be 0 when push == 0.
REQ-021 Sustained throughput SHALL be one word per cycle when at least two queues are non-empty and the destination is not almost full.
REQ-022 After dst_almost_full rises, at most one further push SHALL occur (the in-flight one).
REQ-023 error SHALL set at any edge where push == 1 and dst_full == 1, and SHALL hold until reset.
REQ-024 At most one pop bit SHALL be high in any cycle.

Reset
REQ-025 While reset == 1 at an edge, the block SHALL clear the following on that same edge, regardless of state, dropping any in-flight push:
- state = INIT
- pop = 0, push = 0, data_out = 0
- error = 0
- last_grant = 3

Configuration
REQ-026 Macro ARB_STATS_EN: when defined, the block SHALL add output pop_count (32 bits).
- One 8-bit counter per queue, queue i in [8*i +: 8].
- Counter i increments on each pop[i], saturates at 255, clears on reset.
REQ-027 Without ARB_STATS_EN, the pop_count port and its counters SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset release with empty_in = 4'b1111 -> state goes INIT then IDLE (1 each); pop = 0, push = 0 throughout.
REQ-029 empty_in = 4'b0000, dst flags 0 -> pops are 0001, 0010, 0100, 1000, 0001...
- The first pop is 2 cycles after entering IDLE.
- push follows each pop by 1 cycle.
- data_out equals the matching data_in slice.
REQ-030 Only queue 2 non-empty for 3 cycles -> pop = 0100, 0000, 0100; no consecutive pops of queue 2.
REQ-031 dst_almost_full rises during streaming -> pop is 0 from the next cycle; exactly one trailing push; resumes one cycle after the flag falls.
REQ-032 Force dst_full = 1 while push = 1 -> error = 1 from the next edge and stays 1 until reset; reset mid-stream -> all outputs 0 at the next edge.
REQ-033 With ARB_STATS_EN, 300 pops from queue 1 -> pop_count[15:8] = 255; the other fields count correctly.
